seq_restoring_divider: RTL and testbench
========================================

Name: seq_restoring_divider

Overview:
- Sequential unsigned divider: quotient = dividend / divisor, remainder = dividend % divisor.
- Uses one restoring subtract step per clock.
- It is the inverse-direction companion to the team's combinational ripple adder-subtractor. It is built from a width-extended subtract stage of the same form: invert B, carry-in 1.
- Sits behind a valid/ready handshake in the arithmetic datapath.

Parameters:
- WIDTH, 4, operand, quotient and remainder width in bits (>=2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  divider can accept operands.
- dividend  input  WIDTH  unsigned dividend.
- divisor  input  WIDTH  unsigned divisor.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  WIDTH  unsigned quotient.
- remainder  output  WIDTH  unsigned remainder.
- div_by_zero  output  1  result came from a zero divisor.

Behaviour:
- Reset: asynchronous on rst_n low. State=IDLE; in_ready=1; out_valid=0; quotient, remainder, div_by_zero and step counter all 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: register dividend into quotient shift register, divisor into divisor register; partial remainder=0, counter=0.
  - Divisor!=0 -> CALC. Divisor==0 -> DONE next cycle with quotient=all ones, remainder=dividend, div_by_zero=1.
- CALC (in_ready=0), one step per cycle:
  - Shift {rem, quo} left 1; the dividend MSB enters the rem LSB.
  - trial = {1'b0,rem_shifted} - {1'b0,divisor}, computed as WIDTH+1-bit add of the inverted divisor with carry-in 1.
  - If the trial MSB (borrow) is 0: rem=trial[WIDTH-1:0], quo LSB=1. Otherwise rem is restored (kept) and quo LSB=0.
  - counter++. After step WIDTH-1 completes -> DONE.
  - Latency: accept edge to out_valid high = WIDTH+1 cycles (5 for WIDTH=4).
  - div_by_zero=0 for normal results.
- DONE:
  - out_valid=1. quotient, remainder and div_by_zero are held stable while out_ready=0 (unlimited backpressure).
  - On out_valid && out_ready -> IDLE; out_valid drops next cycle.
  - in_ready=0 in DONE: no accept in the same cycle as result handoff. Minimum issue interval is WIDTH+2 cycles.
- in_valid and operand changes while not in IDLE are ignored. Operands are sampled only at accept.
- Outputs are registered. quotient and remainder show intermediate values during CALC and are only meaningful while out_valid=1.
- Reset mid-CALC or mid-DONE: immediate return to reset state; the in-flight result is lost with no out_valid pulse.
- Arithmetic:
  - Invariant dividend == quotient*divisor + remainder, with remainder < divisor, for divisor!=0.
  - Partial remainder is held in WIDTH bits. The trial subtract is WIDTH+1 bits so borrow is never lost at wrap-around (e.g. rem_shifted=15, divisor=15).
- Counter width: clog2(WIDTH+1).

Decomposition:
- Shared package arith_pkg holds:
  - state enum (IDLE, CALC, DONE);
  - localparam for counter width derived from WIDTH;
  - the all-ones divide-by-zero quotient constant.
- One sub-module: div_sub_stage.
  - Parameterised WIDTH+1-bit ripple subtractor (XOR-invert B, carry-in 1, full-adder chain).
  - Outputs difference and borrow. Purely combinational, instantiated once.

Test Plan:
- 13/3: accept at cycle 0 -> out_valid at cycle 5, quotient=4, remainder=1, div_by_zero=0.
- 15/1 then 3/9 back-to-back, out_ready held 1 -> (15,0) then (0,3). in_ready low from accept until the cycle after each handoff.
- 7/0 -> out_valid 2 cycles after accept, quotient=15, remainder=7, div_by_zero=1.
- 15/15 and 14/15 (borrow boundary) -> (1,0) and (0,14). Also run an exhaustive sweep of all 256 WIDTH=4 pairs against a reference model.
- 9/2 with out_ready=0 for 6 cycles after out_valid -> outputs stay (4,1), out_valid stays 1, in_valid pulses ignored; the handoff then completes.
- 12/5 with rst_n pulsed low on CALC step 2 -> all outputs 0 immediately, in_ready=1 after release, no out_valid. A following 12/5 gives (2,2).

Source files
------------

// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic datapath blocks: the divider FSM state
// encoding, counter sizing and the divide-by-zero quotient pattern.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIV_DEF_W = 4;
  localparam int DIV_MAX_W = 64;

  // Sliced to the operand width by each user.
  localparam logic [DIV_MAX_W-1:0] DIV0_QUOT = '1;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_sub_stage.sv
// Width-extended ripple subtractor: {0,a} - {0,b} as an add of the inverted
// subtrahend with carry-in 1. The extra top sum bit is the borrow.
module div_sub_stage #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  logic [WIDTH:0] ax;
  logic [WIDTH:0] bx;
  logic [WIDTH:0] s;
  logic [WIDTH:0] c;

  assign ax   = {1'b0, a};
  assign bx   = ~{1'b0, b};
  assign c[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s[i]   = ax[i] ^ bx[i] ^ c[i];
    assign c[i+1] = (ax[i] & bx[i]) | (c[i] & (ax[i] ^ bx[i]));
  end

  // The carry out of the extension bit is never needed, only its sum.
  assign s[WIDTH] = ax[WIDTH] ^ bx[WIDTH] ^ c[WIDTH];

  assign diff   = s[WIDTH-1:0];
  assign borrow = s[WIDTH];

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider, one trial subtract per clock, behind
// valid/ready handshakes on both the operand and the result side.
module seq_restoring_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = DIV_DEF_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dbz_q, dbz_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH-1:0] trial;
  logic             borrow;

  // The partial remainder never exceeds the dividend prefix, so the shifted
  // value always fits back into WIDTH bits.
  assign rem_sh = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};

  div_sub_stage #(
    .WIDTH(WIDTH)
  ) u_sub (
    .a     (rem_sh),
    .b     (dvs_q),
    .diff  (trial),
    .borrow(borrow)
  );

  always_comb begin
    state_d = state_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          quo_d   = dividend;
          dvs_d   = divisor;
          rem_d   = '0;
          cnt_d   = '0;
          dbz_d   = (divisor == '0);
          state_d = CALC;
        end
      end
      CALC: begin
        if (dbz_q) begin
          // Zero divisor: one settle cycle, then the fixed result.
          quo_d   = DIV0_QUOT[WIDTH-1:0];
          rem_d   = quo_q;
          state_d = DONE;
        end else begin
          rem_d = borrow ? rem_sh : trial;
          quo_d = {quo_q[WIDTH-2:0], ~borrow};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      dbz_q       <= dbz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and randomized checks of the sequential divider against a plain
// arithmetic reference for quotient, remainder, latency and handshakes.
module tb_seq_restoring_divider;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks   = 0;
  int failures = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_q(input int a, input int b);
    return (b == 0) ? MAXV : a / b;
  endfunction

  function automatic int ref_r(input int a, input int b);
    return (b == 0) ? a : a % b;
  endfunction

  // Called and returns at a negedge; the next call may issue immediately.
  task automatic run(input int a, input int b, input int hold, input string tag);
    int lat;
    int eq, er, ed, el;
    eq = ref_q(a, b);
    er = ref_r(a, b);
    ed = (b == 0) ? 1 : 0;
    el = (b == 0) ? 2 : W + 1;
    check({tag, "_in_ready_idle"}, int'(in_ready), 1);
    in_valid  = 1'b1;
    dividend  = W'(a);
    divisor   = W'(b);
    out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    check({tag, "_in_ready_busy"}, int'(in_ready), 0);
    while (!out_valid && lat < 40) begin
      in_valid = 1'($urandom_range(0, 1));
      dividend = W'($urandom);
      divisor  = W'($urandom);
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, el);
    check({tag, "_quotient"}, int'(quotient), eq);
    check({tag, "_remainder"}, int'(remainder), er);
    check({tag, "_dbz"}, int'(div_by_zero), ed);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom_range(0, 1));
      dividend = W'($urandom);
      divisor  = W'($urandom);
      @(negedge clk);
      check({tag, "_hold_valid"}, int'(out_valid), 1);
      check({tag, "_hold_quotient"}, int'(quotient), eq);
      check({tag, "_hold_remainder"}, int'(remainder), er);
      check({tag, "_hold_in_ready"}, int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_valid_dropped"}, int'(out_valid), 0);
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    #1 rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_quotient", int'(quotient), 0);
    check("reset_remainder", int'(remainder), 0);
    check("reset_dbz", int'(div_by_zero), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run(13, 3, 0, "d13_3");
    run(15, 1, 0, "d15_1");
    run(3, 9, 0, "d3_9");
    run(7, 0, 0, "d7_0");
    run(15, 15, 0, "d15_15");
    run(14, 15, 0, "d14_15");
    run(9, 2, 6, "d9_2_bp");

    // Reset in the middle of a computation.
    in_valid = 1'b1;
    dividend = W'(12);
    divisor  = W'(5);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_quotient", int'(quotient), 0);
    check("midrst_remainder", int'(remainder), 0);
    check("midrst_dbz", int'(div_by_zero), 0);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_no_valid", int'(out_valid), 0);
    end
    check("midrst_ready_after", int'(in_ready), 1);
    run(12, 5, 0, "d12_5_after_rst");

    for (int a = 0; a <= MAXV; a++) begin
      for (int b = 0; b <= MAXV; b++) begin
        run(a, b, 0, $sformatf("sweep_%0d_%0d", a, b));
      end
    end

    for (int i = 0; i < 100; i++) begin
      int ra, rb, rh;
      ra = $urandom_range(0, MAXV);
      rb = $urandom_range(0, MAXV);
      rh = $urandom_range(0, 3);
      run(ra, rb, rh, $sformatf("rand_%0d_%0d_%0d", ra, rb, rh));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
